// File: rtl/spi_motor_cmd_ctrl_pkg.sv
// Shared constants for the SPI motor command decoder: opcodes, readback
// addresses, command word field positions and the settle FSM encoding.
package hr_pi_cmd_pkg;

  localparam logic [7:0] CMD_DRIVE     = 8'h00;
  localparam logic [7:0] CMD_SELECT    = 8'h01;
  localparam logic [7:0] CMD_DRIVE_ALL = 8'h02;
  localparam logic [7:0] CMD_STOP_ALL  = 8'h03;

  localparam logic [7:0] RB_DEBUG    = 8'h00;
  localparam logic [7:0] RB_ENC_BASE = 8'h01;
  localparam logic [7:0] RB_STATUS   = 8'hFE;

  localparam int CMD_MSB = 31;
  localparam int CMD_LSB = 24;
  localparam int SEL_MSB = 7;
  localparam int SEL_LSB = 0;

  typedef enum logic {
    SYNC_IDLE,
    SYNC_SETTLE
  } settle_state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/spi_motor_cmd_ctrl_if.sv
// SPI-slave side word handshake: word-complete flag, received word and the
// readback word returned to the SPI shifter.
interface spi_motor_cmd_ctrl_if;
  logic        data_ready;
  logic [31:0] SPI_data_in;
  logic [31:0] SPI_data_out;

  modport master (output data_ready, output SPI_data_in, input SPI_data_out);
  modport slave  (input data_ready, input SPI_data_in, output SPI_data_out);
endinterface

// File: rtl/spi_motor_cmd_ctrl_ramp.sv
// One motor channel: target period register plus a current period that is
// slew-limited toward the target on each ramp tick.
module motor_ramp #(
  parameter int PWM_WIDTH    = 11,
  parameter int RAMP_STEP    = 0,
  parameter int RESET_PERIOD = 1
) (
  input  logic                 CLK_50,
  input  logic                 reset_n,
  input  logic                 write,
  input  logic [PWM_WIDTH-1:0] value,
  input  logic                 stop,
  input  logic                 tick,
  output logic [PWM_WIDTH-1:0] current
);

  localparam logic [PWM_WIDTH-1:0] RST_VAL = PWM_WIDTH'(RESET_PERIOD);
  localparam logic [31:0]          STEP32  = RAMP_STEP;

  logic [PWM_WIDTH-1:0] target;
  logic [PWM_WIDTH-1:0] diff;
  logic [PWM_WIDTH-1:0] step_amt;
  logic [PWM_WIDTH-1:0] current_next;

  // A tick in the same cycle as a write still steers toward the old target.
  always_comb begin
    diff         = (target >= current) ? (target - current) : (current - target);
    step_amt     = (STEP32 >= 32'(diff)) ? diff : STEP32[PWM_WIDTH-1:0];
    current_next = current;
    if (stop)
      current_next = '0;
    else if (RAMP_STEP == 0)
      current_next = write ? value : target;
    else if (tick) begin
      if (target > current)
        current_next = current + step_amt;
      else if (target < current)
        current_next = current - step_amt;
    end
  end

  always_ff @(posedge CLK_50 or negedge reset_n) begin
    if (!reset_n) begin
      target  <= RST_VAL;
      current <= RST_VAL;
    end else begin
      if (stop)
        target <= '0;
      else if (write)
        target <= value;
      current <= current_next;
    end
  end

endmodule

// File: rtl/spi_motor_cmd_ctrl.sv
// SPI command decoder and motor register file: synchronises data_ready,
// executes command words after a settle delay and drives the readback mux.
module spi_motor_cmd_ctrl
  import hr_pi_cmd_pkg::*;
#(
  parameter int NUM_MOTORS    = 6,
  parameter int NUM_ENC       = 1,
  parameter int PWM_WIDTH     = 11,
  parameter int SETTLE_CYCLES = 11,
  parameter int RAMP_DIV      = 50000,
  parameter int RAMP_STEP     = 0,
  parameter int RESET_PERIOD  = 1
) (
  input  logic                            CLK_50,
  input  logic                            reset_n,
  spi_motor_cmd_ctrl_if.slave             spi,
  input  logic [NUM_ENC*16-1:0]           enc_count,
  input  logic [NUM_ENC-1:0]              enc_dir,
  output logic [NUM_MOTORS*PWM_WIDTH-1:0] motor_periods,
  output logic [PWM_WIDTH-1:0]            debug_period,
  output logic                            cmd_strobe,
  output logic                            cmd_error
);

  localparam int CNT_W    = $clog2(SETTLE_CYCLES + 1);
  localparam int DIV_W    = $clog2(RAMP_DIV + 1);
  localparam int ADDR_LSB = PWM_WIDTH;
  localparam logic [CNT_W-1:0]     SETTLE_LOAD = CNT_W'(SETTLE_CYCLES);
  localparam logic [DIV_W-1:0]     DIV_LAST    = DIV_W'(RAMP_DIV - 1);
  localparam logic [PWM_WIDTH-1:0] RST_VAL     = PWM_WIDTH'(RESET_PERIOD);

  logic dr_meta, dr_sync, dr_prev, rise;
  settle_state_t state, state_next;
  logic [CNT_W-1:0] settle_cnt;
  logic load_cnt, exec, drop;

  logic [7:0]           opcode, maddr, sel_addr, err_count, last_cmd;
  logic [PWM_WIDTH-1:0] value;
  logic [NUM_MOTORS-1:0] write_vec;
  logic valid, stop_all, sel_wr, dbg_wr;
  logic [DIV_W-1:0] div_cnt;
  logic tick;

  always_ff @(posedge CLK_50 or negedge reset_n) begin
    if (!reset_n) begin
      dr_meta <= 1'b0;
      dr_sync <= 1'b0;
      dr_prev <= 1'b0;
    end else begin
      dr_meta <= spi.data_ready;
      dr_sync <= dr_meta;
      dr_prev <= dr_sync;
    end
  end

  assign rise = dr_sync & ~dr_prev;

  always_ff @(posedge CLK_50 or negedge reset_n) begin
    if (!reset_n) state <= SYNC_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      SYNC_IDLE:   if (rise) state_next = SYNC_SETTLE;
      SYNC_SETTLE: if (!rise && settle_cnt == '0) state_next = SYNC_IDLE;
      default:     state_next = SYNC_IDLE;
    endcase
  end

  // A fresh edge while settling restarts the countdown and drops the old word.
  always_comb begin
    load_cnt = rise;
    exec     = (state == SYNC_SETTLE) && !rise && (settle_cnt == '0);
    drop     = (state == SYNC_SETTLE) && rise;
  end

  always_ff @(posedge CLK_50 or negedge reset_n) begin
    if (!reset_n)
      settle_cnt <= '0;
    else if (load_cnt)
      settle_cnt <= SETTLE_LOAD;
    else if (state == SYNC_SETTLE && settle_cnt != '0)
      settle_cnt <= settle_cnt - CNT_W'(1);
  end

  assign opcode = spi.SPI_data_in[CMD_MSB:CMD_LSB];
  assign maddr  = spi.SPI_data_in[ADDR_LSB+7:ADDR_LSB];
  assign value  = spi.SPI_data_in[PWM_WIDTH-1:0];

  always_comb begin
    valid     = 1'b0;
    stop_all  = 1'b0;
    sel_wr    = 1'b0;
    dbg_wr    = 1'b0;
    write_vec = '0;
    if (exec) begin
      case (opcode)
        CMD_DRIVE: begin
          for (int i = 0; i < NUM_MOTORS; i++)
            write_vec[i] = (maddr == 8'(i));
          valid  = (maddr < 8'(NUM_MOTORS));
          dbg_wr = valid;
        end
        CMD_SELECT: begin
          valid  = 1'b1;
          sel_wr = 1'b1;
        end
        CMD_DRIVE_ALL: begin
          valid     = 1'b1;
          dbg_wr    = 1'b1;
          write_vec = '1;
        end
        CMD_STOP_ALL: begin
          valid    = 1'b1;
          stop_all = 1'b1;
        end
        default: valid = 1'b0;
      endcase
    end
  end

  always_ff @(posedge CLK_50 or negedge reset_n) begin
    if (!reset_n) begin
      cmd_strobe   <= 1'b0;
      cmd_error    <= 1'b0;
      err_count    <= 8'h00;
      sel_addr     <= 8'h00;
      last_cmd     <= 8'h00;
      debug_period <= RST_VAL;
    end else begin
      cmd_strobe <= exec & valid;
      cmd_error  <= (exec & ~valid) | drop;
      if ((exec & ~valid) | drop)
        err_count <= sat_inc8(err_count);
      if (exec)
        last_cmd <= opcode;
      if (sel_wr)
        sel_addr <= spi.SPI_data_in[SEL_MSB:SEL_LSB];
      if (dbg_wr)
        debug_period <= value;
    end
  end

  always_ff @(posedge CLK_50 or negedge reset_n) begin
    if (!reset_n) div_cnt <= '0;
    else          div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
  end

  assign tick = (div_cnt == DIV_LAST);

  for (genvar g = 0; g < NUM_MOTORS; g++) begin : g_motor
    motor_ramp #(
      .PWM_WIDTH   (PWM_WIDTH),
      .RAMP_STEP   (RAMP_STEP),
      .RESET_PERIOD(RESET_PERIOD)
    ) u_ramp (
      .CLK_50 (CLK_50),
      .reset_n(reset_n),
      .write  (write_vec[g] & ~stop_all),
      .value  (value),
      .stop   (stop_all),
      .tick   (tick),
      .current(motor_periods[g*PWM_WIDTH +: PWM_WIDTH])
    );
  end

  // Unmapped readback addresses echo the last received word.
  always_comb begin
    spi.SPI_data_out = spi.SPI_data_in;
    if (sel_addr == RB_DEBUG)
      spi.SPI_data_out = 32'(debug_period);
    else if (sel_addr == RB_STATUS)
      spi.SPI_data_out = {16'h0000, err_count, last_cmd};
    else
      for (int k = 0; k < NUM_ENC; k++)
        if (sel_addr == RB_ENC_BASE + 8'(k))
          spi.SPI_data_out = {15'b0, enc_dir[k], enc_count[k*16 +: 16]};
  end

endmodule

// File: tb/tb_spi_motor_cmd_ctrl.sv
// Directed bench: dut0 applies targets immediately, dut1 ramps 100 per
// 4-cycle tick; both share clock, reset and encoder inputs.
module tb_spi_motor_cmd_ctrl;

  logic        CLK_50 = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] enc_count;
  logic        enc_dir;
  logic [65:0] mp0, mp1;
  logic [10:0] dbg0, dbg1;
  logic        stb0, stb1, err0, err1;

  int checks = 0;
  int fails = 0;
  int stbCnt0 = 0;
  int errCnt0 = 0;

  always #10 CLK_50 = ~CLK_50;

  spi_motor_cmd_ctrl_if bus0 ();
  spi_motor_cmd_ctrl_if bus1 ();

  spi_motor_cmd_ctrl #(
    .NUM_MOTORS(6), .NUM_ENC(1), .PWM_WIDTH(11), .SETTLE_CYCLES(11),
    .RAMP_DIV(50000), .RAMP_STEP(0), .RESET_PERIOD(1)
  ) dut0 (
    .CLK_50(CLK_50), .reset_n(reset_n), .spi(bus0.slave),
    .enc_count(enc_count), .enc_dir(enc_dir), .motor_periods(mp0),
    .debug_period(dbg0), .cmd_strobe(stb0), .cmd_error(err0)
  );

  spi_motor_cmd_ctrl #(
    .NUM_MOTORS(6), .NUM_ENC(1), .PWM_WIDTH(11), .SETTLE_CYCLES(11),
    .RAMP_DIV(4), .RAMP_STEP(100), .RESET_PERIOD(1)
  ) dut1 (
    .CLK_50(CLK_50), .reset_n(reset_n), .spi(bus1.slave),
    .enc_count(enc_count), .enc_dir(enc_dir), .motor_periods(mp1),
    .debug_period(dbg1), .cmd_strobe(stb1), .cmd_error(err1)
  );

  always @(posedge CLK_50) begin
    if (stb0 === 1'b1) stbCnt0++;
    if (err0 === 1'b1) errCnt0++;
  end

  function automatic logic [10:0] ch(input logic [65:0] v, input int i);
    return v[i*11 +: 11];
  endfunction

  task automatic checkOutput(input string tag, input logic [95:0] actual,
                             input logic [95:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int which, input logic [31:0] word);
    @(negedge CLK_50);
    if (which == 0) begin bus0.SPI_data_in = word; bus0.data_ready = 1'b1; end
    else            begin bus1.SPI_data_in = word; bus1.data_ready = 1'b1; end
    repeat (20) @(negedge CLK_50);
    bus0.data_ready = 1'b0;
    bus1.data_ready = 1'b0;
    repeat (2) @(negedge CLK_50);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [65:0] rstVec;
    logic [65:0] expVec;
    logic [10:0] seq [4];
    logic [10:0] prev, lastBefore, cur;
    int nChanges, base;
    bit found;

    for (int i = 0; i < 6; i++) rstVec[i*11 +: 11] = 11'd1;
    bus0.data_ready = 1'b0; bus0.SPI_data_in = '0;
    bus1.data_ready = 1'b0; bus1.SPI_data_in = '0;
    enc_count = 16'h1234;
    enc_dir = 1'b1;
    repeat (3) @(negedge CLK_50);
    reset_n = 1'b1;
    @(negedge CLK_50);

    checkOutput("rst_periods0", mp0, rstVec);
    checkOutput("rst_periods1", mp1, rstVec);
    checkOutput("rst_debug", dbg0, 11'd1);
    checkOutput("rst_readback", bus0.SPI_data_out, 32'h0000_0001);
    checkOutput("rst_strobe", stb0, 1'b0);
    checkOutput("rst_error", err0, 1'b0);

    // DRIVE motor 0 = 1000, edge-exact latency
    bus0.SPI_data_in = 32'h0000_03E8;
    bus0.data_ready = 1'b1;
    repeat (14) @(posedge CLK_50);
    #1;
    checkOutput("pre_exec_period", ch(mp0, 0), 11'd1);
    checkOutput("pre_exec_strobe", stb0, 1'b0);
    @(posedge CLK_50);
    #1;
    checkOutput("drive_period", ch(mp0, 0), 11'd1000);
    checkOutput("drive_strobe", stb0, 1'b1);
    checkOutput("drive_debug", dbg0, 11'd1000);
    @(posedge CLK_50);
    #1;
    checkOutput("strobe_one_cycle", stb0, 1'b0);
    repeat (6) @(negedge CLK_50);
    bus0.data_ready = 1'b0;
    repeat (3) @(negedge CLK_50);
    checkOutput("drive_strobe_count", stbCnt0, 1);

    // Bad motor address and bad opcode
    applyStimulus(0, 32'h0000_3055);
    expVec = rstVec;
    expVec[10:0] = 11'd1000;
    checkOutput("bad_addr_errors", errCnt0, 1);
    checkOutput("bad_addr_periods", mp0, expVec);
    checkOutput("bad_addr_debug", dbg0, 11'd1000);
    applyStimulus(0, 32'h7F00_0000);
    checkOutput("bad_opcode_errors", errCnt0, 2);
    checkOutput("bad_opcode_strobes", stbCnt0, 1);

    // Readback mux
    applyStimulus(0, 32'h0100_0001);
    checkOutput("rb_encoder", bus0.SPI_data_out, 32'h0001_1234);
    applyStimulus(0, 32'h0100_00FE);
    checkOutput("rb_status", bus0.SPI_data_out, 32'h0000_0201);
    checkOutput("select_strobes", stbCnt0, 3);

    // Two edges three cycles apart: only the second word executes
    @(negedge CLK_50);
    bus0.SPI_data_in = 32'h0000_1877;
    bus0.data_ready = 1'b1;
    @(negedge CLK_50);
    bus0.data_ready = 1'b0;
    repeat (2) @(negedge CLK_50);
    bus0.SPI_data_in = 32'h0000_1123;
    bus0.data_ready = 1'b1;
    repeat (20) @(negedge CLK_50);
    bus0.data_ready = 1'b0;
    repeat (2) @(negedge CLK_50);
    checkOutput("dropped_errors", errCnt0, 3);
    checkOutput("dropped_strobes", stbCnt0, 4);
    checkOutput("dropped_status", bus0.SPI_data_out, 32'h0000_0300);
    checkOutput("second_word_m2", ch(mp0, 2), 11'h123);
    checkOutput("first_word_m3", ch(mp0, 3), 11'd1);

    applyStimulus(0, 32'h0100_0005);
    bus0.SPI_data_in = 32'hCAFE_F00D;
    #1;
    checkOutput("rb_echo", bus0.SPI_data_out, 32'hCAFE_F00D);

    // Ramp on dut1: DRIVE_ALL 250 from 1
    @(negedge CLK_50);
    bus1.SPI_data_in = 32'h0200_00FA;
    bus1.data_ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge CLK_50);
      if (stb1 === 1'b1) found = 1'b1;
    end
    checkOutput("ramp_strobe_seen", found, 1'b1);
    nChanges = 0;
    prev = ch(mp1, 0);
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK_50);
      if (i == 5) bus1.data_ready = 1'b0;
      cur = ch(mp1, 0);
      if (cur != prev) begin
        if (nChanges < 4) seq[nChanges] = cur;
        nChanges++;
      end
      prev = cur;
    end
    checkOutput("ramp_steps", nChanges, 3);
    checkOutput("ramp_first", seq[0], 11'd101);
    checkOutput("ramp_second", seq[1], 11'd201);
    checkOutput("ramp_final", seq[2], 11'd250);
    checkOutput("ramp_ch5", ch(mp1, 5), 11'd250);
    checkOutput("ramp_debug", dbg1, 11'd250);

    // STOP_ALL while ramping toward 1000
    bus1.SPI_data_in = 32'h0200_03E8;
    bus1.data_ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge CLK_50);
      if (stb1 === 1'b1) found = 1'b1;
    end
    checkOutput("ramp2_strobe_seen", found, 1'b1);
    bus1.data_ready = 1'b0;
    repeat (2) @(negedge CLK_50);
    bus1.SPI_data_in = 32'h0300_0000;
    bus1.data_ready = 1'b1;
    found = 1'b0;
    lastBefore = '0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge CLK_50);
      if (stb1 === 1'b1) found = 1'b1;
      else lastBefore = ch(mp1, 0);
    end
    checkOutput("stop_strobe_seen", found, 1'b1);
    checkOutput("stop_mid_ramp", (lastBefore > 11'd250 && lastBefore < 11'd1000), 1'b1);
    checkOutput("stop_all_zero", mp1, 66'd0);
    bus1.data_ready = 1'b0;
    repeat (12) @(negedge CLK_50);
    checkOutput("stop_holds", mp1, 66'd0);

    // Reset during countdown
    @(negedge CLK_50);
    bus0.SPI_data_in = 32'h0000_09F4;
    bus0.data_ready = 1'b1;
    repeat (8) @(negedge CLK_50);
    #3 reset_n = 1'b0;
    #1;
    checkOutput("async_rst_periods", mp0, rstVec);
    checkOutput("async_rst_debug", dbg0, 11'd1);
    checkOutput("async_rst_readback", bus0.SPI_data_out, 32'h0000_0001);
    bus0.data_ready = 1'b0;
    @(negedge CLK_50);
    reset_n = 1'b1;
    base = stbCnt0;
    repeat (30) @(negedge CLK_50);
    checkOutput("no_strobe_after_rst", stbCnt0, base);
    checkOutput("pending_discarded", ch(mp0, 1), 11'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
